// File: rtl/dmrfalu_ctrl.sv
// dmrfalu_ctrl -- multi-cycle control FSM for a small load/store ALU datapath.
// Issues one instruction at a time through IDLE -> DECODE -> EXEC -> (MEM) -> WB.
// All control outputs are Moore outputs held in flops. They are computed from the
// next state and next latched opcode/funct, so they change on the same edge as the
// state register.
module dmrfalu_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic [5:0] FuncCode,
  output logic       ALUSrc,
  output logic       sel,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  typedef struct packed {
    logic       ready;
    logic       done;
    logic       err;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [5:0] func_code;
    logic       alu_src;
    logic       sel;
  } ctrl_t;

  logic [2:0] state_r;
  logic [5:0] op_r;
  logic [5:0] funct_r;
  ctrl_t      ctrl_r;

  logic [2:0] state_nxt_s;
  logic [5:0] op_nxt_s;
  logic [5:0] funct_nxt_s;
  ctrl_t      ctrl_nxt_s;

  // True for the four opcodes this controller knows how to sequence.
  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
  endfunction

  // True for opcodes that go through the memory stage.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Moore decode of the control word from a state code and the latched fields.
  function automatic ctrl_t decode_ctrl(input logic [2:0] st,
                                        input logic [5:0] op,
                                        input logic [5:0] fn);
    ctrl_t c;
    logic  active;
    c      = '0;
    active = (st == S_EXEC) || (st == S_MEM) || (st == S_WB);
    c.ready     = (st == S_IDLE);
    c.err       = (st == S_DECODE) && !is_legal(op);
    c.alu_op    = (active && (op == OP_RTYPE)) ? 2'b10 : 2'b00;
    c.alu_src   = active && ((op == OP_LW) || (op == OP_SW) || (op == OP_ADDI));
    c.mem_read  = (st == S_MEM) && (op == OP_LW);
    c.mem_write = (st == S_MEM) && (op == OP_SW);
    c.reg_write = (st == S_WB);
    c.sel       = (st == S_WB) && (op == OP_LW);
    c.done      = (st == S_WB) || ((st == S_MEM) && (op == OP_SW));
    c.func_code = (op == OP_RTYPE) ? fn : 6'h00;
    return c;
  endfunction

  // Next-state and operand-latch logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = S_IDLE;
    op_nxt_s    = op_r;
    funct_nxt_s = funct_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_DECODE;
          op_nxt_s    = opcode;
          funct_nxt_s = funct;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DECODE: begin
        if (is_legal(op_r)) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC: begin
        if (is_mem_op(op_r)) begin
          state_nxt_s = S_MEM;
        end else begin
          state_nxt_s = S_WB;
        end
      end
      S_MEM: begin
        if (op_r == OP_LW) begin
          state_nxt_s = S_WB;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WB: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        // Unused codes 5-7 fall back to IDLE.
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Control word that goes with the next state, so the outputs stay aligned with state.
  always_comb begin
    ctrl_nxt_s = decode_ctrl(state_nxt_s, op_nxt_s, funct_nxt_s);
  end

  // State, operand latches and registered control outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      op_r    <= 6'h00;
      funct_r <= 6'h00;
      ctrl_r  <= decode_ctrl(S_IDLE, 6'h00, 6'h00);
    end else begin
      state_r <= state_nxt_s;
      op_r    <= op_nxt_s;
      funct_r <= funct_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
    end
  end

  assign ready    = ctrl_r.ready;
  assign done     = ctrl_r.done;
  assign err      = ctrl_r.err;
  assign MemWrite = ctrl_r.mem_write;
  assign MemRead  = ctrl_r.mem_read;
  assign RegWrite = ctrl_r.reg_write;
  assign ALUOp    = ctrl_r.alu_op;
  assign FuncCode = ctrl_r.func_code;
  assign ALUSrc   = ctrl_r.alu_src;
  assign sel      = ctrl_r.sel;
  assign state    = state_r;

endmodule

// File: tb/tb_dmrfalu_ctrl.sv
// tb_dmrfalu_ctrl -- directed and random-stream bench for dmrfalu_ctrl.
// A per-instruction schedule model predicts the full output word every cycle.
module tb_dmrfalu_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ready, done, err, MemWrite, MemRead, RegWrite, ALUSrc, sel;
  logic [1:0] ALUOp;
  logic [5:0] FuncCode;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  dmrfalu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct(funct),
    .ready(ready), .done(done), .err(err), .MemWrite(MemWrite), .MemRead(MemRead),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .FuncCode(FuncCode), .ALUSrc(ALUSrc),
    .sel(sel), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: a queue of expected per-cycle output words ----------
  // word = {state, ready, done, err, MemWrite, MemRead, RegWrite, ALUOp, FuncCode, ALUSrc, sel}
  logic [18:0] sched[$];
  logic [18:0] exp_cur;
  logic [5:0]  lat_op, lat_fn;
  bit          model_on = 1'b0;
  int          accepted = 0;
  int          aborted  = 0;
  int          dut_term = 0;

  function automatic logic [18:0] mk(input logic [2:0] st, input logic rdy, input logic dn,
                                     input logic er, input logic mw, input logic mr,
                                     input logic rw, input logic [1:0] aop,
                                     input logic [5:0] fc, input logic src, input logic sl);
    return {st, rdy, dn, er, mw, mr, rw, aop, fc, src, sl};
  endfunction

  function automatic logic [18:0] idle_rec(input logic [5:0] op, input logic [5:0] fn);
    return mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
              (op == 6'h00) ? fn : 6'h00, 1'b0, 1'b0);
  endfunction

  // Lay out every cycle an accepted instruction will spend outside IDLE.
  task automatic push_sched(input logic [5:0] op, input logic [5:0] fn);
    logic       rt, lw, sw, ad, legal;
    logic [5:0] fc;
    logic [1:0] aop;
    rt = (op == 6'h00); lw = (op == 6'h23); sw = (op == 6'h2B); ad = (op == 6'h08);
    legal = rt | lw | sw | ad;
    fc  = rt ? fn : 6'h00;
    aop = rt ? 2'b10 : 2'b00;
    sched.push_back(mk(3'd1, 1'b0, 1'b0, !legal, 1'b0, 1'b0, 1'b0, 2'b00, fc, 1'b0, 1'b0));
    if (legal) begin
      sched.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, aop, fc, !rt, 1'b0));
      if (lw) begin
        sched.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, aop, fc, 1'b1, 1'b0));
        sched.push_back(mk(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, aop, fc, 1'b1, 1'b1));
      end else if (sw) begin
        sched.push_back(mk(3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, aop, fc, 1'b1, 1'b0));
      end else begin
        sched.push_back(mk(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, aop, fc, !rt, 1'b0));
      end
    end
  endtask

  // Model advance: one schedule entry per clock, new work only when idle.
  initial begin
    exp_cur = '0;
    lat_op  = 6'h00;
    lat_fn  = 6'h00;
    forever begin
      @(posedge clk);
      if (rst) begin
        if (sched.size() > 1) aborted++;
        sched.delete();
        lat_op   = 6'h00;
        lat_fn   = 6'h00;
        model_on = 1'b1;
      end else if (sched.size() != 0) begin
        void'(sched.pop_front());
      end else if (start) begin
        lat_op = opcode;
        lat_fn = funct;
        accepted++;
        push_sched(opcode, funct);
      end
      exp_cur = (sched.size() != 0) ? sched[0] : idle_rec(lat_op, lat_fn);
    end
  end

  // Compare the whole output word against the model every cycle after reset.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        chk("cycle_word", {state, ready, done, err, MemWrite, MemRead, RegWrite,
                           ALUOp, FuncCode, ALUSrc, sel}, exp_cur);
        chk("strobe_excl", ((32'(MemRead) + 32'(MemWrite) + 32'(RegWrite)) <= 32'd1), 1);
        if (done || err) dut_term++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  // Present one instruction for a single accepting edge; returns at cycle 1.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn);
    start = 1'b1; opcode = op; funct = fn;
    cyc();
    start = 1'b0;
  endtask

  logic [5:0] op_tab[6];

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 6'h00; funct = 6'h00;
    op_tab[0] = 6'h00; op_tab[1] = 6'h23; op_tab[2] = 6'h2B;
    op_tab[3] = 6'h08; op_tab[4] = 6'h3F; op_tab[5] = 6'h11;
    repeat (2) cyc();
    chk("rst_state", state, 3'd0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_outs", {done, err, MemWrite, MemRead, RegWrite, ALUOp, FuncCode, ALUSrc, sel}, 0);
    rst = 1'b0;

    // R-type add
    issue(6'h00, 6'h20);
    chk("rt_c1_state", state, 3'd1);
    cyc();
    chk("rt_c2_aluop", ALUOp, 2'b10);
    chk("rt_c2_func", FuncCode, 6'h20);
    cyc();
    chk("rt_c3_wb", {RegWrite, sel, done}, 3'b101);
    cyc();
    chk("rt_c4_ready", ready, 1'b1);

    // LW issued back-to-back
    issue(6'h23, 6'h00);
    cyc(); cyc();
    chk("lw_c3_mem", {state, MemRead, ALUSrc, MemWrite}, {3'd3, 3'b110});
    cyc();
    chk("lw_c4_wb", {RegWrite, sel, done}, 3'b111);
    cyc();

    // SW
    issue(6'h2B, 6'h00);
    cyc(); cyc();
    chk("sw_c3_mem", {MemWrite, done, RegWrite}, 3'b110);
    cyc();
    chk("sw_c4_idle", {state, ready}, {3'd0, 1'b1});

    // illegal opcode
    issue(6'h3F, 6'h00);
    chk("ill_c1_err", {state, err, MemRead, MemWrite, RegWrite}, {3'd1, 4'b1000});
    cyc();
    chk("ill_c2_idle", {state, err}, {3'd0, 1'b0});

    // ADDI
    issue(6'h08, 6'h15);
    cyc(); cyc();
    chk("addi_c3_wb", {state, done, ALUSrc, ALUOp, FuncCode}, {3'd4, 2'b11, 2'b00, 6'h00});
    cyc();

    // abort a load while it sits in MEM
    issue(6'h23, 6'h00);
    cyc(); cyc();
    chk("abort_pre_mr", MemRead, 1'b1);
    rst = 1'b1;
    cyc();
    chk("abort_post", {state, ready, MemRead, done}, {3'd0, 3'b100});
    rst = 1'b0;

    // start held high while busy: latches must not follow the live inputs
    start = 1'b1; opcode = 6'h00; funct = 6'h22;
    cyc();
    opcode = 6'h2B; funct = 6'h03;
    chk("busy_c1_state", state, 3'd1);
    cyc();
    chk("busy_c2_latch", {ALUOp, FuncCode}, {2'b10, 6'h22});
    cyc();
    chk("busy_c3_done", done, 1'b1);
    cyc();
    chk("busy_c4_ready", {state, ready}, {3'd0, 1'b1});
    cyc();
    chk("busy_c5_accept", state, 3'd1);
    start = 1'b0;
    repeat (3) cyc();

    // random stream of legal/illegal ops with occasional resets
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      start  = $urandom_range(0, 1) != 0;
      opcode = op_tab[$urandom_range(0, 5)];
      funct  = 6'($urandom_range(0, 63));
      cyc();
    end
    rst = 1'b0; start = 1'b0;

    // drain, bounded
    for (int i = 0; i < 10; i++) begin
      if (ready && (sched.size() == 0)) break;
      cyc();
    end
    chk("drain_ready", ready, 1'b1);
    chk("term_count", dut_term, accepted - aborted);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
